// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: round-robin write/read arbiter driving a single-port RAM, with a read-valid pipeline
module sp_ram_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_gnt,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);
    logic            last_wr;
    logic [RD_LAT:0] rd_pipe;
    // write yields only when contended and it was the last one served
    always_comb begin
        wr_gnt = !rst && wr_req && !(rd_req && last_wr);
        rd_gnt = !rst && rd_req && !wr_gnt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_wr  <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            rd_pipe  <= '0;
        end else begin
            ram_we  <= wr_gnt;
            rd_pipe <= {rd_pipe[RD_LAT-1:0], rd_gnt};
            ram_addr <= wr_gnt ? wr_addr : rd_gnt ? rd_addr : ram_addr;
            ram_din  <= wr_gnt ? wr_data : ram_din;
            last_wr  <= (wr_gnt || rd_gnt) ? wr_gnt : last_wr;
        end
    end
    assign rd_valid = rd_pipe[RD_LAT];
    assign rd_data  = ram_dout;
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb_sp_ram_arbiter: directed tables, corner sequences and random traffic against a transaction-level model
module tb_sp_ram_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0, rd_req = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;

    logic          wr_gnt1, rd_gnt1, rd_valid1, ram_we1;
    logic [DW-1:0] rd_data1, ram_din1, ram_dout1;
    logic [AW-1:0] ram_addr1;
    logic          wr_gnt2, rd_gnt2, rd_valid2, ram_we2;
    logic [DW-1:0] rd_data2, ram_din2, ram_dout2;
    logic [AW-1:0] ram_addr2;

    always #5 clk = ~clk;

    sp_ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt1),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt1),
        .rd_valid(rd_valid1), .rd_data(rd_data1),
        .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_din(ram_din1), .ram_dout(ram_dout1)
    );

    sp_ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt2),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt2),
        .rd_valid(rd_valid2), .rd_data(rd_data2),
        .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_din(ram_din2), .ram_dout(ram_dout2)
    );

    // behavioural single-port RAMs with 1 and 2 cycles of read latency
    logic [DW-1:0] mem1 [0:(1<<AW)-1];
    logic [DW-1:0] mem2 [0:(1<<AW)-1];
    logic [DW-1:0] q1a, q2a, q2b;
    always @(posedge clk) begin
        if (ram_we1) mem1[ram_addr1] <= ram_din1;
        q1a <= mem1[ram_addr1];
    end
    always @(posedge clk) begin
        if (ram_we2) mem2[ram_addr2] <= ram_din2;
        q2a <= mem2[ram_addr2];
        q2b <= q2a;
    end
    assign ram_dout1 = q1a;
    assign ram_dout2 = q2b;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // transaction-level model of the RD_LAT=1 instance
    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } pend_t;
    pend_t         pq[$];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int            cyc = 0;
    int            last_srv = 1;
    logic          exp_we = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_din = '0;

    task automatic mon();
        logic ew, er;
        if (rst) begin
            chk("rst_wr_gnt", wr_gnt1, 0);
            chk("rst_rd_gnt", rd_gnt1, 0);
            chk("rst_rd_valid", rd_valid1, 0);
            chk("rst_rd_valid2", rd_valid2, 0);
            chk("rst_ram_we", ram_we1, 0);
            chk("rst_ram_addr", ram_addr1, 0);
            chk("rst_ram_din", ram_din1, 0);
            exp_we = 0; exp_addr = '0; exp_din = '0; last_srv = 1;
            pq.delete();
        end else begin
            ew = wr_req && (!rd_req || last_srv == 1);
            er = rd_req && !ew;
            chk("wr_gnt", wr_gnt1, ew);
            chk("rd_gnt", rd_gnt1, er);
            chk("ram_we", ram_we1, exp_we);
            chk("ram_addr", ram_addr1, exp_addr);
            chk("ram_din", ram_din1, exp_din);
            if (pq.size() > 0 && pq[0].due == cyc) begin
                chk("rd_valid", rd_valid1, 1);
                chk("rd_data", rd_data1, pq[0].d);
                void'(pq.pop_front());
            end else begin
                chk("rd_valid_idle", rd_valid1, 0);
            end
            if (ew) begin
                shadow[wr_addr] = wr_data;
                exp_we = 1; exp_addr = wr_addr; exp_din = wr_data; last_srv = 0;
            end else if (er) begin
                pq.push_back('{cyc + 2, shadow[rd_addr]});
                exp_we = 0; exp_addr = rd_addr; last_srv = 1;
            end else begin
                exp_we = 0;
            end
        end
        cyc++;
    endtask

    logic          c_wg, c_rg, c_v, c_we, c_rg2, c_v2;
    logic [DW-1:0] c_d, c_d2;

    task automatic step();
        @(negedge clk);
        mon();
        c_wg = wr_gnt1; c_rg = rd_gnt1; c_v = rd_valid1; c_d = rd_data1; c_we = ram_we1;
        c_rg2 = rd_gnt2; c_v2 = rd_valid2; c_d2 = rd_data2;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; wr_req = 0; rd_req = 0;
        step();
        step();
        rst = 0;
    endtask

    typedef struct {
        logic w, r, gw, gr, we;
    } vec_t;
    vec_t tbl[15];

    initial begin
        logic [DW-1:0] got[$];
        int            k_found;
        logic [DW-1:0] d_found;
        logic          gw, gr;

        tbl[0]  = '{1, 1, 1, 0, 0};
        tbl[1]  = '{1, 1, 0, 1, 1};
        tbl[2]  = '{1, 1, 1, 0, 0};
        tbl[3]  = '{1, 1, 0, 1, 1};
        tbl[4]  = '{1, 1, 1, 0, 0};
        tbl[5]  = '{1, 1, 0, 1, 1};
        tbl[6]  = '{1, 0, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 1};
        tbl[8]  = '{0, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0};
        tbl[12] = '{1, 1, 0, 1, 0};
        tbl[13] = '{0, 1, 0, 1, 0};
        tbl[14] = '{1, 1, 1, 0, 0};

        #1;
        do_reset();

        // arbitration table: alternation, idle hold of priority, single requesters
        wr_addr = AW'(4); wr_data = DW'(16); rd_addr = AW'(4);
        for (int i = 0; i < 15; i++) begin
            wr_req = tbl[i].w; rd_req = tbl[i].r;
            step();
            chk($sformatf("tbl%0d_wr_gnt", i), c_wg, tbl[i].gw);
            chk($sformatf("tbl%0d_rd_gnt", i), c_rg, tbl[i].gr);
            chk($sformatf("tbl%0d_ram_we", i), c_we, tbl[i].we);
        end
        wr_req = 0; rd_req = 0;
        for (int i = 0; i < 4; i++) step();

        // fill addresses 0..9 with i*i, then read them back-to-back
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr_req = 1; wr_addr = AW'(i); wr_data = DW'(i * i);
            step();
            chk("fill_wr_gnt", c_wg, 1);
        end
        wr_req = 0;
        for (int i = 0; i < 10; i++) begin
            rd_req = 1; rd_addr = AW'(i);
            step();
            chk("fill_rd_gnt", c_rg, 1);
            if (c_v) got.push_back(c_d);
        end
        rd_req = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (c_v) got.push_back(c_d);
        end
        chk("fill_pulse_count", got.size(), 10);
        for (int i = 0; i < 10 && i < got.size(); i++) chk($sformatf("fill_data%0d", i), got[i], DW'(i * i));

        // read-after-write on consecutive grants returns the new data
        wr_req = 1; wr_addr = AW'(5); wr_data = 32'hDEADBEEF;
        step();
        wr_req = 0; rd_req = 1; rd_addr = AW'(5);
        step();
        chk("raw_rd_gnt", c_rg, 1);
        rd_req = 0;
        k_found = 0; d_found = '0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (c_v && k_found == 0) begin k_found = k; d_found = c_d; end
        end
        chk("raw_latency", k_found, 2);
        chk("raw_data", d_found, 32'hDEADBEEF);

        // reset with reads in flight suppresses their pulses
        for (int i = 0; i < 3; i++) begin
            rd_req = 1; rd_addr = AW'(i);
            step();
            chk("flush_rd_gnt", c_rg, 1);
        end
        rd_req = 0; rst = 1;
        step();
        chk("flush_rst_valid", c_v, 0);
        chk("flush_rst_we", c_we, 0);
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("flush_no_valid", c_v, 0);
            chk("flush_no_valid2", c_v2, 0);
        end

        // RD_LAT=2 instance: write addr 3 = 9, read it back
        wr_req = 1; wr_addr = AW'(3); wr_data = DW'(9);
        step();
        wr_req = 0; rd_req = 1; rd_addr = AW'(3);
        step();
        chk("lat2_rd_gnt", c_rg2, 1);
        rd_req = 0;
        k_found = 0; d_found = '0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (c_v2 && k_found == 0) begin k_found = k; d_found = c_d2; end
        end
        chk("lat2_latency", k_found, 3);
        chk("lat2_data", d_found, 9);

        // random traffic; requesters hold their request until granted
        gw = 0; gr = 0;
        for (int n = 0; n < 400; n++) begin
            if (!wr_req || gw) begin
                wr_req = 1'($urandom_range(0, 1));
                wr_addr = AW'($urandom_range(0, 9));
                wr_data = $urandom;
            end
            if (!rd_req || gr) begin
                rd_req = 1'($urandom_range(0, 1));
                rd_addr = AW'($urandom_range(0, 9));
            end
            step();
            gw = c_wg; gr = c_rg;
        end
        wr_req = 0; rd_req = 0;
        for (int i = 0; i < 5; i++) step();
        chk("drain_pending", pq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sp_ram_arbiter.md
SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 10, RAM address width in bits.
REQ-002 The block SHALL have parameter DW, default 32, RAM data width in bits.
REQ-003 The block SHALL have parameter RD_LAT, default 1, RAM clock-to-dout latency in cycles; legal values 1 and 2.
REQ-004 The block SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port wr_req, input, 1, write requester asks for a RAM slot.
REQ-007 The block SHALL have port wr_addr, input, AW, write address.
REQ-008 The block SHALL have port wr_data, input, DW, write data.
REQ-009 The block SHALL have port wr_gnt, output, 1, write accepted this cycle.
REQ-010 The block SHALL have port rd_req, input, 1, read requester asks for a RAM slot.
REQ-011 The block SHALL have port rd_addr, input, AW, read address.
REQ-012 The block SHALL have port rd_gnt, output, 1, read accepted this cycle.
REQ-013 The block SHALL have port rd_valid, output, 1, rd_data carries the result of one accepted read.
REQ-014 The block SHALL have port rd_data, output, DW, read result.
REQ-015 The block SHALL have port ram_we, output, 1, single-port RAM write enable.
REQ-016 The block SHALL have port ram_addr, output, AW, RAM address.
REQ-017 The block SHALL have port ram_din, output, DW, RAM write data.
REQ-018 The block SHALL have port ram_dout, input, DW, RAM read data.

Function
REQ-019 A requester SHALL hold req, addr and data stable until it sees its gnt high; a transfer occurs in a cycle where req and gnt are both high.
REQ-020 wr_gnt and rd_gnt SHALL be combinational from req inputs and the priority state, never both high in one cycle, and low when the matching req is low.
REQ-021 With only one req high, that requester SHALL be granted in the same cycle.
REQ-022 With both high, the requester not served in the most recent granted cycle SHALL win (round-robin); a waiting requester SHALL be granted within 1 cycle.
REQ-023 The priority state SHALL update only on cycles with a grant; idle cycles SHALL not change it.
REQ-024 On a write grant, at the next edge ram_we<=1, ram_addr<=wr_addr, ram_din<=wr_data.
REQ-025 On a read grant, at the next edge ram_we<=0, ram_addr<=rd_addr; ram_din SHALL hold its value.
REQ-026 With no grant, at the next edge ram_we<=0; ram_addr and ram_din SHALL hold their values.
REQ-027 For a read granted in cycle T, rd_valid SHALL be high in cycle T+1+RD_LAT only, with rd_data equal to ram_dout in that cycle.
REQ-028 rd_data SHALL be ram_dout passed through combinationally; rd_valid SHALL come from an RD_LAT+1 stage shift register of read grants.
REQ-029 Back-to-back read grants SHALL produce back-to-back rd_valid pulses, in grant order.
REQ-030 A write granted in cycle T followed by a read of the same address granted in T+1 SHALL return the new data.
REQ-031 A read granted before a write to the same address SHALL return the old data.

Reset
REQ-032 While rst is high, ram_we, wr_gnt, rd_gnt and rd_valid SHALL be 0; ram_addr and ram_din SHALL be 0; the rd_valid pipeline SHALL be cleared.
REQ-033 Priority after reset SHALL favour write: the first contended cycle grants write.
REQ-034 A reset asserted with reads in flight SHALL suppress all their rd_valid pulses; none SHALL appear after rst deasserts.
REQ-035 Requests SHALL be granted from the first rising edge after rst deasserts.

Verification
REQ-036 Bench SHALL cover: write addr i data i*i for i=0..9 (wr_req only), then read addr 0..9 -> 10 rd_valid pulses, each 2 cycles after its grant for RD_LAT=1, data 0,1,4,...,81 in order.
REQ-037 Bench SHALL cover: wr_req and rd_req both held high for 6 cycles after reset -> grants alternate W,R,W,R,W,R; ram_we pattern 1,0,1,0,1,0 one cycle later.
REQ-038 Bench SHALL cover: write addr 5 data 0xDEADBEEF, then a read of addr 5 on the next cycle -> rd_valid with 0xDEADBEEF.
REQ-039 Bench SHALL cover: 3 back-to-back reads, then rst pulsed 1 cycle after the last grant -> no rd_valid pulse; all outputs 0 during reset.
REQ-040 Bench SHALL cover: RD_LAT=2, read addr 3 (holding 9) -> rd_valid exactly 3 cycles after grant with rd_data=9.
REQ-041 Bench SHALL cover: idle 5 cycles between requests -> ram_we 0, ram_addr unchanged, priority unchanged (next contention grants the requester not last served).
